// File: rtl/v_pkg.sv
// Shared types and constants for the vector store unit.
//   vst_state_t    : store FSM states
//   VOP_VSE/VSSE   : v_lsu_op codes for unit-stride / strided store
//   SEW_E8/16/32   : vsew encodings
//   DEF_ADDR_W     : default word-address width
//   vst_last_beat  : index of the final beat for a given op/lmul/sew
package v_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} vst_state_t;

    localparam logic [3:0] VOP_VSE  = 4'd7;
    localparam logic [3:0] VOP_VSSE = 4'd8;

    localparam int unsigned VST_PORTS = 4;

    localparam logic [1:0] SEW_E8  = 2'd0;
    localparam logic [1:0] SEW_E16 = 2'd1;
    localparam logic [1:0] SEW_E32 = 2'd2;

    localparam int unsigned DEF_ADDR_W = 30;

    // Unit-stride moves whole registers (1 << lmul beats); strided moves four
    // elements per beat out of (128 << lmul) >> (3 + sew) elements.
    function automatic logic [3:0] vst_last_beat(input logic       unit,
                                                 input logic [1:0] lmul,
                                                 input logic [1:0] sew);
        logic [5:0] beats;
        if (unit) beats = 6'd1 << lmul;
        else      beats = (6'd4 << lmul) >> sew;
        return 4'(beats - 6'd1);
    endfunction

endpackage

// File: rtl/v_store_lane.sv
// One store port: maps an element's byte address to a word address, moves the
// element into its byte lane and forms the byte enables.
//   byte_addr  in  32      element byte address
//   elem       in  32      element value, right-aligned
//   sew        in  2       element width (E32 also used for unit-stride words)
//   lane_mask  in  4       per-byte enable mask (all ones when unmasked)
//   word_addr  out ADDR_W  byte_addr[ADDR_W+1:2]
//   data       out 32      lane-aligned data
//   we         out 4       byte enables, zero when misaligned
//   misalign   out 1       element not aligned to its width
module v_store_lane
    import v_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic [31:0]       byte_addr,
    input  logic [31:0]       elem,
    input  logic [1:0]        sew,
    input  logic [3:0]        lane_mask,
    output logic [ADDR_W-1:0] word_addr,
    output logic [31:0]       data,
    output logic [3:0]        we,
    output logic              misalign
);

    logic [1:0]  off;
    logic [31:0] val;
    logic [3:0]  base_we;

    always_comb begin
        off       = byte_addr[1:0];
        word_addr = ADDR_W'({2'b00, byte_addr[31:2]});
        case (sew)
            SEW_E8: begin
                val      = {24'h0, elem[7:0]};
                base_we  = 4'b0001;
                misalign = 1'b0;
            end
            SEW_E16: begin
                val      = {16'h0, elem[15:0]};
                base_we  = 4'b0011;
                misalign = off[0];
            end
            default: begin
                val      = elem;
                base_we  = 4'b1111;
                misalign = (off != 2'b00);
            end
        endcase
        data = val << {off, 3'b000};
        we   = misalign ? 4'b0000 : ((base_we << off) & lane_mask);
    end

endmodule

// File: rtl/v_storeu.sv
// Vector store unit: streams a captured register group (up to 4*VLEN bits) to
// data memory as 128-bit beats over four 32-bit store ports.
// Optional feature: define STORE_MASK_EN to add the v0_mask input; masked-off
// elements get zero byte enables but every beat is still issued.
//   clk, nrst (async, active-high)
//   start, v_lsu_op, vsew, lmul, s_addr, s_stride, s_data_in : request, IDLE only
//   mem_ready                                 : memory accepts the current beat
//   s_valid, data_addr0..3, s_data_out0..3, write_en0..3      : registered beat
//   busy, s_done, s_err                       : status / completion
module v_storeu
    import v_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned VLEN   = 128
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [3:0]        v_lsu_op,
    input  logic [2:0]        vsew,
    input  logic [2:0]        lmul,
    input  logic [31:0]       s_addr,
    input  logic [31:0]       s_stride,
    input  logic [4*VLEN-1:0] s_data_in,
`ifdef STORE_MASK_EN
    input  logic [127:0]      v0_mask,
`endif
    input  logic              mem_ready,
    output logic              s_valid,
    output logic [ADDR_W-1:0] data_addr0,
    output logic [ADDR_W-1:0] data_addr1,
    output logic [ADDR_W-1:0] data_addr2,
    output logic [ADDR_W-1:0] data_addr3,
    output logic [31:0]       s_data_out0,
    output logic [31:0]       s_data_out1,
    output logic [31:0]       s_data_out2,
    output logic [31:0]       s_data_out3,
    output logic [3:0]        write_en0,
    output logic [3:0]        write_en1,
    output logic [3:0]        write_en2,
    output logic [3:0]        write_en3,
    output logic              busy,
    output logic              s_done,
    output logic              s_err
);

    vst_state_t state_q, state_d;

    logic [3:0]        beat_q, last_q;
    logic [31:0]       base_q, stride_q;
    logic [4*VLEN-1:0] data_q;
    logic              unit_q;
    logic [1:0]        sew_q;
    logic              err_q;
`ifdef STORE_MASK_EN
    logic [127:0]      mask_q;
    logic [127:0]      src_mask;
`endif

    logic [VST_PORTS-1:0][ADDR_W-1:0] addr_q;
    logic [VST_PORTS-1:0][31:0]       dout_q;
    logic [VST_PORTS-1:0][3:0]        we_q;

    logic [VST_PORTS-1:0][ADDR_W-1:0] lane_waddr;
    logic [VST_PORTS-1:0][31:0]       lane_data;
    logic [VST_PORTS-1:0][3:0]        lane_we;
    logic [VST_PORTS-1:0]             lane_mis;

    logic              idle, in_unit, accept, start_err, last_beat, advance, load;
    logic              src_unit;
    logic [1:0]        src_sew, lane_sew;
    logic [31:0]       src_stride, nxt_base;
    logic [4*VLEN-1:0] src_data;
    logic [3:0]        nxt_beat;
    logic [2:0]        shamt;
    logic [31:0]       stride_mul [VST_PORTS];

    assign idle      = (state_q == ST_IDLE);
    assign in_unit   = (v_lsu_op == VOP_VSE);
    assign accept    = idle && start && (in_unit || v_lsu_op == VOP_VSSE);
    assign start_err = (lmul > 3'd2) || (vsew > 3'd2) || (in_unit && s_addr[1:0] != 2'b00);
    assign last_beat = (beat_q == last_q);
    assign advance   = (state_q == ST_ISSUE) && mem_ready;
    assign load      = (accept && !start_err) || (advance && !last_beat);

    // In IDLE the first beat is built straight from the request inputs so it
    // can be registered on the accepting edge; afterwards from latched copies.
    assign src_unit   = idle ? in_unit   : unit_q;
    assign src_sew    = idle ? vsew[1:0] : sew_q;
    assign src_stride = idle ? s_stride  : stride_q;
    assign src_data   = idle ? s_data_in : data_q;
`ifdef STORE_MASK_EN
    assign src_mask   = idle ? v0_mask   : mask_q;
`endif
    assign nxt_beat   = idle ? 4'd0 : beat_q + 4'd1;
    // base_q tracks the address of element 4*beat (accumulator, no multiplier)
    assign nxt_base   = idle ? s_addr
                             : base_q + (src_unit ? 32'd16 : {stride_q[29:0], 2'b00});
    // Unit-stride moves whole 32-bit words regardless of vsew
    assign lane_sew   = src_unit ? SEW_E32 : src_sew;
    assign shamt      = src_unit ? 3'd5 : 3'd3 + {1'b0, src_sew};

    always_comb begin
        stride_mul[0] = 32'd0;
        stride_mul[1] = src_stride;
        stride_mul[2] = {src_stride[30:0], 1'b0};
        stride_mul[3] = src_stride + {src_stride[30:0], 1'b0};
    end

    for (genvar p = 0; p < VST_PORTS; p++) begin : g_lane
        logic [5:0]  idx;
        logic [10:0] bitoff;
        logic [31:0] elem;
        logic [31:0] baddr;
        logic [3:0]  mask;

        assign idx    = {nxt_beat, 2'(p)};
        assign bitoff = 11'(idx) << shamt;
        assign elem   = 32'(src_data >> bitoff);
        assign baddr  = nxt_base + (src_unit ? 32'(4 * p) : stride_mul[p]);

`ifdef STORE_MASK_EN
        // Unit-stride words hold several elements; mask each byte by its element
        always_comb begin
            mask = 4'b0000;
            for (int b = 0; b < 4; b++) begin
                if (!src_unit) begin
                    mask[b] = src_mask[7'(idx)];
                end else begin
                    case (src_sew)
                        SEW_E8:  mask[b] = src_mask[7'({idx, 2'(b)})];
                        SEW_E16: mask[b] = src_mask[7'({idx, 1'(b >> 1)})];
                        default: mask[b] = src_mask[7'(idx)];
                    endcase
                end
            end
        end
`else
        assign mask = 4'b1111;
`endif

        v_store_lane #(.ADDR_W(ADDR_W)) u_lane (
            .byte_addr (baddr),
            .elem      (elem),
            .sew       (lane_sew),
            .lane_mask (mask),
            .word_addr (lane_waddr[p]),
            .data      (lane_data[p]),
            .we        (lane_we[p]),
            .misalign  (lane_mis[p])
        );
    end

    // FSM: state register
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = start_err ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (advance && last_beat) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        s_valid = (state_q == ST_ISSUE);
        s_done  = (state_q == ST_DONE);
        s_err   = (state_q == ST_DONE) && err_q;
        busy    = (state_q != ST_IDLE);
    end

    // Datapath: request latches, beat counter, address accumulator, beat regs
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            beat_q   <= '0;
            last_q   <= '0;
            base_q   <= '0;
            stride_q <= '0;
            data_q   <= '0;
            unit_q   <= 1'b0;
            sew_q    <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            we_q     <= '0;
`ifdef STORE_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            if (accept) begin
                unit_q   <= in_unit;
                sew_q    <= vsew[1:0];
                stride_q <= s_stride;
                data_q   <= s_data_in;
                last_q   <= vst_last_beat(in_unit, lmul[1:0], vsew[1:0]);
                err_q    <= start_err;
`ifdef STORE_MASK_EN
                mask_q   <= v0_mask;
`endif
            end
            if (load) begin
                beat_q <= nxt_beat;
                base_q <= nxt_base;
                addr_q <= lane_waddr;
                dout_q <= lane_data;
                we_q   <= lane_we;
                // Misaligned elements accumulate into a sticky error
                err_q  <= (idle ? 1'b0 : err_q) | (|lane_mis);
            end
            if (advance && last_beat) begin
                beat_q <= '0;
                we_q   <= '0;
            end
        end
    end

    assign data_addr0  = addr_q[0];
    assign data_addr1  = addr_q[1];
    assign data_addr2  = addr_q[2];
    assign data_addr3  = addr_q[3];
    assign s_data_out0 = dout_q[0];
    assign s_data_out1 = dout_q[1];
    assign s_data_out2 = dout_q[2];
    assign s_data_out3 = dout_q[3];
    assign write_en0   = we_q[0];
    assign write_en1   = we_q[1];
    assign write_en2   = we_q[2];
    assign write_en3   = we_q[3];

endmodule
